vc_buffer_bank: RTL and testbench
=================================

Name: vc_buffer_bank

Overview:
- Multi-virtual-channel circular FIFO bank for router input ports: NUM_VC independent queues of DEPTH entries, each WIDTH bits wide.
- One write and one read per cycle. The write and read channels are selected independently by VC index.
- Feeds the VC allocator and crossbar: gives per-VC full/empty/almost-full bitmaps, plus a first-word-fall-through head word and occupancy for the selected read VC.
- Generalises the single-queue buffer: multiple channels, power-of-two depth with full-capacity occupancy counters, almost-full back-pressure, and overflow/underflow detection.

Parameters:
- WIDTH, 64, flit width in bits.
- DEPTH, 8, entries per VC; power of two, at least 2.
- NUM_VC, 4, number of virtual channels; at least 1.
- AF_THRESH, 6, almost_full[v] asserts when count[v] >= AF_THRESH; range 1..DEPTH.
- Derived values:
  - PW = clog2(DEPTH), the pointer width.
  - CW = PW+1, the count width.
  - VW = max(1, clog2(NUM_VC)), the VC index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_vc  in  VW  VC index for the write
- wr_data  in  WIDTH  flit to enqueue
- produce  in  1  enqueue request into wr_vc
- rd_vc  in  VW  VC index for the read / head view
- consume  in  1  dequeue request from rd_vc
- rd_data  out  WIDTH  head flit of rd_vc, combinational; 0 when rd_vc is empty
- rd_valid  out  1  equals ~empty[rd_vc]
- rd_usedw  out  CW  count[rd_vc], combinational
- full  out  NUM_VC  per-VC full, count == DEPTH
- empty  out  NUM_VC  per-VC empty, count == 0
- almost_full  out  NUM_VC  per-VC count >= AF_THRESH
- overflow  out  1  sticky; set by a rejected produce
- err_cnt  out  16  error event counter; see Optional Feature

Behaviour:
- Storage is a single array of NUM_VC*DEPTH entries; VC v owns entries v*DEPTH .. v*DEPTH+DEPTH-1.
- Each VC has:
  - head[v] and tail[v], PW bits each, wrapping naturally modulo DEPTH;
  - count[v], CW bits, so all DEPTH entries are usable (no sacrificed slot).
- Reset, synchronous, active-high:
  - all head, tail and count registers = 0; overflow = 0; err_cnt = 0;
  - storage is not cleared.
  - Resulting outputs: empty = all 1s, full = 0, almost_full = 0, rd_valid = 0, rd_data = 0, rd_usedw = 0.
  - rst has priority over produce/consume in the same cycle. Reset mid-stream discards all contents.
- Write: a produce accepted while ~full[wr_vc] writes wr_data to slot tail[wr_vc] and increments tail and count at the clock edge. The data becomes visible on rd_data at the earliest on the next cycle.
- Rejected write: produce while full[wr_vc] changes no state (no data write, no pointer movement) and sets overflow.
- Read: consume while ~empty[rd_vc] advances head[rd_vc] and decrements count. rd_data shows the next head in the following cycle, with no read latency (FWFT).
- Rejected read: consume while empty[rd_vc] is ignored; no state change.
- Same cycle, different VCs: both operations proceed independently.
- Same cycle, same VC:
  - Non-empty and non-full: both proceed; count is unchanged.
  - Full: the consume proceeds and the produce is rejected (full is evaluated before the consume).
  - Empty: the produce proceeds and the consume is rejected; there is no bypass.
- wr_vc/rd_vc values >= NUM_VC (when NUM_VC is not a power of two): the operation is ignored. rd_data = 0 and rd_valid = 0 in that case.
- All flag outputs are decoded combinationally from the count registers.

Optional Feature:
- Macro: VC_BUFFER_ERR_CNT_EN.
- Defined: err_cnt is a 16-bit counter that increments by 1 per cycle with a rejected produce, and by 1 per cycle with a rejected consume. Both in one cycle increments it by 2. It saturates at 16'hFFFF and is cleared only by rst.
- Undefined: the counter logic is not built and err_cnt is tied to 0. overflow behaves identically in both builds.

Test Plan:
- Reset, then idle → empty = 4'b1111, full = 0, almost_full = 0, rd_valid = 0, rd_data = 0, rd_usedw = 0.
- Fill VC2 with 8 writes of data 0x10..0x17, rd_vc = 2:
  - after the 6th write, almost_full = 4'b0100;
  - after the 8th write, full = 4'b0100 and rd_usedw = 8;
  - a 9th write of 0xFF → overflow = 1, contents unchanged;
  - 8 reads return 0x10..0x17 in order, then empty[2] = 1.
- Wrap-around on VC0: write 5, read 5, write 8 (0xA0..0xA7), read 8 → data 0xA0..0xA7 in order; head and tail cross the boundary correctly.
- Simultaneous operations:
  - write VC1 and read VC3 in the same cycle → independent counts;
  - same VC with count 3 → rd_usedw stays 3;
  - same VC full → read succeeds, write rejected, count becomes 7;
  - same VC empty → count becomes 1, rd_data equals the written flit next cycle.
- Reset mid-operation with VC0 and VC3 partially filled and produce = 1 in the reset cycle → all empty next cycle, overflow = 0, and no write occurs.
- With VC_BUFFER_ERR_CNT_EN: 3 rejected writes plus 2 reads from empty, one cycle pairing both → err_cnt = 5. Without the macro, the same stimulus → err_cnt = 0.

Source files
------------

// File: rtl/vc_buffer_bank.sv
// Multi-VC circular FIFO bank: NUM_VC first-word-fall-through queues sharing one storage array.
// Optional error-event counter on err_cnt_o is built only when VC_BUFFER_ERR_CNT_EN is defined.
module vc_buffer_bank #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 8,
  parameter int NUM_VC    = 4,
  parameter int AF_THRESH = 6,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VW-1:0]     wr_vc_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              produce_i,
  input  logic [VW-1:0]     rd_vc_i,
  input  logic              consume_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic [CW-1:0]     rd_usedw_o,
  output logic [NUM_VC-1:0] full_o,
  output logic [NUM_VC-1:0] empty_o,
  output logic [NUM_VC-1:0] almost_full_o,
  output logic              overflow_o,
  output logic [15:0]       err_cnt_o
);

  localparam int AW = VW + PW;

  // produce/consume are fire-and-forget requests: an enqueue is taken only when the
  // addressed VC is not full, a dequeue only when it is not empty; otherwise it is dropped.

  logic [WIDTH-1:0]  mem_q   [NUM_VC*DEPTH];
  logic [PW-1:0]     head_q  [NUM_VC];
  logic [PW-1:0]     head_d  [NUM_VC];
  logic [PW-1:0]     tail_q  [NUM_VC];
  logic [PW-1:0]     tail_d  [NUM_VC];
  logic [CW-1:0]     count_q [NUM_VC];
  logic [CW-1:0]     count_d [NUM_VC];
  logic              overflow_q;

  logic              wr_in_range, rd_in_range;
  logic [VW-1:0]     wr_idx, rd_idx;
  logic              wr_ok, wr_rej, rd_ok;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [NUM_VC-1:0] full_v, empty_v, af_v;

  always_comb begin
    full_v  = '0;
    empty_v = '0;
    af_v    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full_v[v]  = (count_q[v] == CW'(DEPTH));
      empty_v[v] = (count_q[v] == '0);
      af_v[v]    = (count_q[v] >= CW'(AF_THRESH));
    end
  end

  // Out-of-range VC indices are neutralised here so every array access stays in bounds.
  assign wr_in_range = (32'(wr_vc_i) < NUM_VC);
  assign rd_in_range = (32'(rd_vc_i) < NUM_VC);
  assign wr_idx      = wr_in_range ? wr_vc_i : '0;
  assign rd_idx      = rd_in_range ? rd_vc_i : '0;

  assign wr_ok  = !rst && produce_i && wr_in_range && !full_v[wr_idx];
  assign wr_rej = !rst && produce_i && wr_in_range &&  full_v[wr_idx];
  assign rd_ok  = !rst && consume_i && rd_in_range && !empty_v[rd_idx];

  assign wr_addr = AW'(wr_idx) * AW'(DEPTH) + AW'(tail_q[wr_idx]);
  assign rd_addr = AW'(rd_idx) * AW'(DEPTH) + AW'(head_q[rd_idx]);

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      logic wr_sel, rd_sel;
      wr_sel     = wr_ok && (wr_idx == VW'(v));
      rd_sel     = rd_ok && (rd_idx == VW'(v));
      head_d[v]  = rd_sel ? head_q[v] + 1'b1 : head_q[v];
      tail_d[v]  = wr_sel ? tail_q[v] + 1'b1 : tail_q[v];
      count_d[v] = count_q[v] + CW'(wr_sel) - CW'(rd_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v]  <= '0;
        tail_q[v]  <= '0;
        count_q[v] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_q | wr_rej;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= wr_data_i;
  end

  assign rd_valid_o    = rd_in_range && !empty_v[rd_idx];
  assign rd_data_o     = rd_valid_o ? mem_q[rd_addr] : '0;
  assign rd_usedw_o    = rd_in_range ? count_q[rd_idx] : '0;
  assign full_o        = full_v;
  assign empty_o       = empty_v;
  assign almost_full_o = af_v;
  assign overflow_o    = overflow_q;

`ifdef VC_BUFFER_ERR_CNT_EN
  logic        rd_rej;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  assign rd_rej = !rst && consume_i && rd_in_range && empty_v[rd_idx];

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 17'(wr_rej) + 17'(rd_rej);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vc_buffer_bank.sv
// Bench for vc_buffer_bank: constant-vector table, directed corner sequences and
// randomized traffic checked against a per-VC queue model.
module tb_vc_buffer_bank;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 8;
  localparam int NUM_VC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        wr_vc, rd_vc;
  logic [WIDTH-1:0]  wr_data;
  logic              produce, consume;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic [3:0]        rd_usedw;
  logic [3:0]        full, empty, almost_full;
  logic              overflow;
  logic [15:0]       err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one queue per VC plus sticky/event counters.
  logic [WIDTH-1:0] mq [NUM_VC][$];
  bit               ovf_m;
  int               err_m;

  vc_buffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst),
    .wr_vc_i(wr_vc), .wr_data_i(wr_data), .produce_i(produce),
    .rd_vc_i(rd_vc), .consume_i(consume),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_usedw_o(rd_usedw),
    .full_o(full), .empty_o(empty), .almost_full_o(almost_full),
    .overflow_o(overflow), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit wfull, rempty;
    wfull  = (mq[wr_vc].size() == DEPTH);
    rempty = (mq[rd_vc].size() == 0);
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) mq[v].delete();
      ovf_m = 1'b0;
      err_m = 0;
    end else begin
      if (produce) begin
        if (wfull) begin ovf_m = 1'b1; err_m++; end
        else mq[wr_vc].push_back(wr_data);
      end
      if (consume) begin
        if (rempty) err_m++;
        else void'(mq[rd_vc].pop_front());
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]  ef, ee, ea;
    logic [63:0] ed;
    logic [15:0] eerr;
    for (int v = 0; v < NUM_VC; v++) begin
      ef[v] = (mq[v].size() == DEPTH);
      ee[v] = (mq[v].size() == 0);
      ea[v] = (mq[v].size() >= 6);
    end
    ed = (mq[rd_vc].size() != 0) ? mq[rd_vc][0] : 64'h0;
`ifdef VC_BUFFER_ERR_CNT_EN
    eerr = (err_m > 65535) ? 16'hFFFF : 16'(err_m);
`else
    eerr = 16'h0;
`endif
    check({tag, ".full"},     full,        ef);
    check({tag, ".empty"},    empty,       ee);
    check({tag, ".afull"},    almost_full, ea);
    check({tag, ".rd_data"},  rd_data,     ed);
    check({tag, ".rd_valid"}, rd_valid,    mq[rd_vc].size() != 0);
    check({tag, ".rd_usedw"}, rd_usedw,    mq[rd_vc].size());
    check({tag, ".overflow"}, overflow,    ovf_m);
    check({tag, ".err_cnt"},  err_cnt,     eerr);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic cycle(input logic r, input logic [1:0] wv, input logic [63:0] d,
                       input logic p, input logic [1:0] rv, input logic c);
    rst = r; wr_vc = wv; wr_data = d; produce = p; rd_vc = rv; consume = c;
    @(posedge clk);
    model_step();
    #1;
    check_model("model");
  endtask

  typedef struct {
    logic [1:0]  wv;
    logic [63:0] d;
    logic        p;
    logic [1:0]  rv;
    logic        c;
    logic [3:0]  e_full;
    logic [3:0]  e_af;
    logic [3:0]  e_empty;
    logic [3:0]  e_usedw;
    logic [63:0] e_data;
    logic        e_valid;
    logic        e_ovf;
  } vec_t;

  initial begin
    vec_t tbl [17];
    logic [15:0] exp_err;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{2'd2, 64'h10 + 64'(i), 1'b1, 2'd2, 1'b0,
                 (i == 7) ? 4'b0100 : 4'b0000, (i >= 5) ? 4'b0100 : 4'b0000,
                 4'b1011, 4'(i + 1), 64'h10, 1'b1, 1'b0};
    tbl[8] = '{2'd2, 64'hFF, 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0100, 4'b1011,
               4'd8, 64'h10, 1'b1, 1'b1};
    for (int j = 0; j < 8; j++)
      tbl[9 + j] = '{2'd2, 64'h0, 1'b0, 2'd2, 1'b1, 4'b0000,
                     (7 - j >= 6) ? 4'b0100 : 4'b0000,
                     (j == 7) ? 4'b1111 : 4'b1011, 4'(7 - j),
                     (j < 7) ? 64'h11 + 64'(j) : 64'h0, (j < 7), 1'b1};

    rst = 1'b1; wr_vc = '0; rd_vc = '0; wr_data = '0; produce = 1'b0; consume = 1'b0;
    ovf_m = 1'b0; err_m = 0;

    // Reset, then idle
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("reset.empty",    empty,       4'b1111);
    check("reset.full",     full,        4'b0000);
    check("reset.afull",    almost_full, 4'b0000);
    check("reset.rd_valid", rd_valid,    1'b0);
    check("reset.rd_data",  rd_data,     64'h0);
    check("reset.rd_usedw", rd_usedw,    4'd0);
    check("reset.overflow", overflow,    1'b0);

    // Fill / overflow / drain VC2 from the constant table
    for (int i = 0; i < 17; i++) begin
      cycle(0, tbl[i].wv, tbl[i].d, tbl[i].p, tbl[i].rv, tbl[i].c);
      check($sformatf("tbl%0d.full", i),     full,        tbl[i].e_full);
      check($sformatf("tbl%0d.afull", i),    almost_full, tbl[i].e_af);
      check($sformatf("tbl%0d.empty", i),    empty,       tbl[i].e_empty);
      check($sformatf("tbl%0d.usedw", i),    rd_usedw,    tbl[i].e_usedw);
      check($sformatf("tbl%0d.data", i),     rd_data,     tbl[i].e_data);
      check($sformatf("tbl%0d.valid", i),    rd_valid,    tbl[i].e_valid);
      check($sformatf("tbl%0d.overflow", i), overflow,    tbl[i].e_ovf);
    end

    // Wrap-around on VC0
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 64'h50 + 64'(i), 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 64'hA0 + 64'(i), 1, 0, 0);
    check("wrap.usedw", rd_usedw, 4'd8);
    check("wrap.full",  full,     4'b0001);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wrap.data%0d", i), rd_data, 64'hA0 + 64'(i));
      cycle(0, 0, 0, 0, 0, 1);
    end
    check("wrap.empty", empty, 4'b1111);

    // Simultaneous operations
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 3, 64'h30, 1, 3, 0);
    cycle(0, 3, 64'h31, 1, 3, 0);
    cycle(0, 1, 64'h11, 1, 3, 1);
    check("sim.diff.usedw3", rd_usedw, 4'd1);
    check("sim.diff.data3",  rd_data,  64'h31);
    check("sim.diff.empty",  empty,    4'b0101);
    cycle(0, 1, 64'h12, 1, 1, 0);
    cycle(0, 1, 64'h13, 1, 1, 0);
    check("sim.same3.pre", rd_usedw, 4'd3);
    cycle(0, 1, 64'h14, 1, 1, 1);
    check("sim.same3.usedw", rd_usedw, 4'd3);
    check("sim.same3.data",  rd_data,  64'h12);
    for (int i = 0; i < 8; i++) cycle(0, 0, 64'hC0 + 64'(i), 1, 0, 0);
    cycle(0, 0, 64'hEE, 1, 0, 1);
    check("sim.full.usedw",    rd_usedw, 4'd7);
    check("sim.full.data",     rd_data,  64'hC1);
    check("sim.full.overflow", overflow, 1'b1);
    cycle(0, 2, 64'h55, 1, 2, 1);
    check("sim.empty.usedw", rd_usedw, 4'd1);
    check("sim.empty.data",  rd_data,  64'h55);
    check("sim.empty.valid", rd_valid, 1'b1);

    // Reset mid-stream with a produce in the reset cycle
    cycle(1, 3, 64'h77, 1, 3, 0);
    check("midrst.empty",    empty,    4'b1111);
    check("midrst.overflow", overflow, 1'b0);
    check("midrst.usedw",    rd_usedw, 4'd0);
    cycle(0, 0, 0, 0, 3, 0);
    check("midrst.idle.usedw", rd_usedw, 4'd0);
    check("midrst.idle.valid", rd_valid, 1'b0);

    // Error events: 3 rejected writes, 2 rejected reads, one cycle pairing both
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 64'hB0 + 64'(i), 1, 0, 0);
    cycle(0, 1, 64'hE1, 1, 0, 0);
    cycle(0, 1, 64'hE2, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 64'hE3, 1, 0, 1);
`ifdef VC_BUFFER_ERR_CNT_EN
    exp_err = 16'd5;
`else
    exp_err = 16'd0;
`endif
    check("err.cnt",      err_cnt,  exp_err);
    check("err.overflow", overflow, 1'b1);

    // Randomized traffic
    cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 199) == 0),
            2'($urandom_range(0, 3)), {$urandom, $urandom},
            ($urandom_range(0, 99) < 60),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 55));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
